// File: rtl/ram_arbiter_if.sv
// Bundle of CPU-side, host-side and RAM-side signals around the RAM arbiter.
// The arbiter takes the slave view; the surrounding system drives the master view.
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          cpu_boundary;
    logic          cpu_we;
    logic          cpu_oe;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_halt;

    logic          host_req;
    logic          host_gnt;
    logic          host_valid;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;

    logic          ram_we;
    logic          ram_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          owner;

    modport slave (
        input  cpu_boundary, cpu_we, cpu_oe, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_halt,
        input  host_req, host_valid, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output ram_we, ram_oe, ram_addr, ram_wdata,
        input  ram_rdata,
        output owner
    );

    modport master (
        output cpu_boundary, cpu_we, cpu_oe, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_halt,
        output host_req, host_valid, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  ram_we, ram_oe, ram_addr, ram_wdata,
        output ram_rdata,
        input  owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port program/data RAM (CPU vs host loader/debug port).
// Define ARB_BURST_LIMIT_EN to force the host to yield after BURST_MAX beats per tenure.
module ram_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int BURST_MAX = 16
) (
    input logic          clk,
    input logic          reset,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_CPU,
        ST_DRAIN,
        ST_HOST,
        ST_RETURN
    } state_e;

    state_e        state_q, state_d;
    logic          cpu_halt_q;
    logic          host_gnt_q;
    logic          host_rvalid_q;
    logic [DW-1:0] host_rdata_q;
    logic          host_beat;
    logic          host_rd;

    // A beat presented while the request is being withdrawn is dropped.
    assign host_beat = (state_q == ST_HOST) && bus.host_req && bus.host_valid;
    assign host_rd   = host_beat && !bus.host_we;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(BURST_MAX + 1);

    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          yield_q, yield_d;
    logic          last_beat;

    assign last_beat = host_beat && (beat_cnt_q == CW'(BURST_MAX - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_CPU;
            cpu_halt_q    <= 1'b0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
`ifdef ARB_BURST_LIMIT_EN
            beat_cnt_q    <= '0;
            yield_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cpu_halt_q    <= (state_d == ST_DRAIN) || (state_d == ST_HOST);
            host_gnt_q    <= (state_d == ST_HOST);
            host_rvalid_q <= host_rd;
            if (host_rd) begin
                host_rdata_q <= bus.ram_rdata;
            end
`ifdef ARB_BURST_LIMIT_EN
            beat_cnt_q    <= beat_cnt_d;
            yield_q       <= yield_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef ARB_BURST_LIMIT_EN
        beat_cnt_d = beat_cnt_q;
        yield_d    = yield_q;
`endif
        case (state_q)
            ST_CPU: begin
`ifdef ARB_BURST_LIMIT_EN
                // After a forced yield, one instruction boundary must pass first.
                if (yield_q) begin
                    if (bus.cpu_boundary) begin
                        yield_d = 1'b0;
                    end
                end else if (bus.host_req) begin
                    state_d = ST_DRAIN;
                end
`else
                if (bus.host_req) begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            ST_DRAIN: begin
                if (!bus.host_req) begin
                    state_d = ST_RETURN;
                end else if (bus.cpu_boundary) begin
                    state_d = ST_HOST;
                end
            end
            ST_HOST: begin
                if (!bus.host_req) begin
                    state_d = ST_RETURN;
                end
`ifdef ARB_BURST_LIMIT_EN
                else if (host_beat) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = ST_RETURN;
                        yield_d = 1'b1;
                    end
                end
`endif
            end
            ST_RETURN: begin
                state_d = ST_CPU;
`ifdef ARB_BURST_LIMIT_EN
                beat_cnt_d = '0;
`endif
            end
            default: state_d = ST_CPU;
        endcase
    end

    // RETURN leaves both strobes low: the guaranteed dead cycle between owners.
    always_comb begin
        bus.ram_we    = 1'b0;
        bus.ram_oe    = 1'b0;
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.cpu_rdata = '0;
        case (state_q)
            ST_CPU, ST_DRAIN: begin
                bus.ram_we    = bus.cpu_we && !reset;
                bus.ram_oe    = bus.cpu_oe;
                bus.cpu_rdata = bus.ram_rdata;
            end
            ST_HOST: begin
                bus.ram_addr  = bus.host_addr;
                bus.ram_wdata = bus.host_wdata;
                bus.ram_we    = host_beat && bus.host_we && !reset;
                bus.ram_oe    = host_rd;
            end
            default: ;
        endcase
    end

    assign bus.cpu_halt    = cpu_halt_q;
    assign bus.host_gnt    = host_gnt_q;
    assign bus.owner       = host_gnt_q;
    assign bus.host_rvalid = host_rvalid_q;
    assign bus.host_rdata  = host_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized plus directed bench for ram_arbiter against a tenure-level reference model.
// Build with ARB_BURST_LIMIT_EN defined to exercise the burst limit with BURST_MAX = 4.
module tb_ram_arbiter;
`ifdef ARB_BURST_LIMIT_EN
    localparam bit LIMIT = 1'b1;
    localparam int BMAX  = 4;
`else
    localparam bit LIMIT = 1'b0;
    localparam int BMAX  = 16;
`endif

    typedef enum {PH_CPU, PH_WAIT, PH_HOST, PH_GAP} phase_e;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_arbiter_if #(.AW(8), .DW(8)) bus ();

    ram_arbiter #(.AW(8), .DW(8), .BURST_MAX(BMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [7:0] mem    [256];
    logic [7:0] refMem [256];
    assign bus.ram_rdata = mem[bus.ram_addr];

    int         total = 0;
    int         bad   = 0;
    phase_e     ph = PH_CPU;
    int         beats = 0;
    bit         yieldHold = 1'b0;
    bit         modelValid = 1'b0;
    bit         expRvalid = 1'b0;
    logic [7:0] expRdata = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit cpuOwns();
        return (ph == PH_CPU) || (ph == PH_WAIT);
    endfunction

    function automatic bit hostBeat();
        return (ph == PH_HOST) && bus.host_req && bus.host_valid;
    endfunction

    task automatic checkAll();
        bit expWe, expOe;
        expWe = !reset && (cpuOwns() ? bus.cpu_we : (hostBeat() && bus.host_we));
        expOe = cpuOwns() ? bus.cpu_oe : (hostBeat() && !bus.host_we);
        checkOutput("cpu_halt", bus.cpu_halt, (ph == PH_WAIT) || (ph == PH_HOST));
        checkOutput("host_gnt", bus.host_gnt, ph == PH_HOST);
        checkOutput("owner", bus.owner, ph == PH_HOST);
        checkOutput("ram_we", bus.ram_we, expWe);
        checkOutput("ram_oe", bus.ram_oe, expOe);
        if (cpuOwns()) checkOutput("ram_addr_cpu", bus.ram_addr, bus.cpu_addr);
        else if (hostBeat()) checkOutput("ram_addr_host", bus.ram_addr, bus.host_addr);
        if (expWe) checkOutput("ram_wdata", bus.ram_wdata, cpuOwns() ? bus.cpu_wdata : bus.host_wdata);
        checkOutput("cpu_rdata", bus.cpu_rdata, cpuOwns() ? refMem[bus.cpu_addr] : 8'h00);
        checkOutput("host_rvalid", bus.host_rvalid, expRvalid);
        checkOutput("host_rdata", bus.host_rdata, expRdata);
    endtask

    task automatic updateModel();
        bit         we, rd;
        logic [7:0] addr, data;
        if (reset) begin
            ph = PH_CPU; beats = 0; yieldHold = 1'b0;
            expRvalid = 1'b0; expRdata = 8'h00; modelValid = 1'b1;
            return;
        end
        if (!modelValid) return;
        we   = cpuOwns() ? bus.cpu_we : (hostBeat() && bus.host_we);
        rd   = hostBeat() && !bus.host_we;
        addr = cpuOwns() ? bus.cpu_addr : bus.host_addr;
        data = cpuOwns() ? bus.cpu_wdata : bus.host_wdata;
        expRvalid = rd;
        if (rd) expRdata = refMem[bus.host_addr];
        if (we) refMem[addr] = data;
        case (ph)
            PH_CPU:
                if (yieldHold) begin
                    if (bus.cpu_boundary) yieldHold = 1'b0;
                end else if (bus.host_req) ph = PH_WAIT;
            PH_WAIT:
                if (!bus.host_req) ph = PH_GAP;
                else if (bus.cpu_boundary) ph = PH_HOST;
            PH_HOST:
                if (!bus.host_req) ph = PH_GAP;
                else if (bus.host_valid) begin
                    beats++;
                    if (LIMIT && beats == BMAX) begin
                        ph = PH_GAP;
                        yieldHold = 1'b1;
                    end
                end
            PH_GAP: begin
                beats = 0;
                ph = PH_CPU;
            end
            default: ph = PH_CPU;
        endcase
    endtask

    // One clock cycle with the currently driven inputs: check, clock, update RAM and model.
    task automatic applyStimulus(input int n = 1);
        bit         sWe;
        logic [7:0] sAddr, sData;
        for (int c = 0; c < n; c++) begin
            #6;
            if (modelValid) checkAll();
            else checkOutput("reset_we", bus.ram_we, 1'b0);
            sWe = (bus.ram_we === 1'b1);
            sAddr = bus.ram_addr;
            sData = bus.ram_wdata;
            @(posedge clk);
            if (sWe) mem[sAddr] = sData;
            updateModel();
            #1;
        end
    endtask

    task automatic idleInputs();
        bus.cpu_boundary = 1'b0; bus.cpu_we = 1'b0; bus.cpu_oe = 1'b0;
        bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
        bus.host_req = 1'b0; bus.host_valid = 1'b0; bus.host_we = 1'b0;
        bus.host_addr = 8'h00; bus.host_wdata = 8'h00;
    endtask

    initial begin
        int reqLeft;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            refMem[i] = 8'h00;
        end
        reset = 1'b1;
        idleInputs();
        @(posedge clk);
        #1;
        applyStimulus(2);
        reset = 1'b0;
        applyStimulus(2);

        $display("[TB] request while CPU is mid-instruction");
        bus.host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.cpu_we = (i == 2);
            bus.cpu_addr = 8'h03;
            bus.cpu_wdata = 8'h3C;
            applyStimulus();
        end
        bus.cpu_we = 1'b0;
        bus.cpu_boundary = 1'b1;
        applyStimulus();
        bus.cpu_boundary = 1'b0;

        $display("[TB] host write then read");
        bus.host_valid = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 8'h10; bus.host_wdata = 8'hA5;
        applyStimulus();
        bus.host_we = 1'b0;
        applyStimulus();
        bus.host_valid = 1'b0;
        applyStimulus();

        $display("[TB] release with a beat on the withdrawal cycle");
        bus.host_valid = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 8'h11; bus.host_wdata = 8'h77;
        bus.host_req = 1'b0;
        applyStimulus();
        bus.host_valid = 1'b0;
        bus.cpu_addr = 8'h11; bus.cpu_oe = 1'b1;
        applyStimulus(2);
        bus.cpu_oe = 1'b0;

        $display("[TB] withdrawal coinciding with boundary");
        bus.host_req = 1'b1;
        applyStimulus();
        bus.host_req = 1'b0; bus.cpu_boundary = 1'b1;
        applyStimulus();
        bus.cpu_boundary = 1'b0;
        applyStimulus(2);

        $display("[TB] continuous write burst");
        bus.host_req = 1'b1;
        applyStimulus();
        bus.cpu_boundary = 1'b1;
        applyStimulus();
        bus.cpu_boundary = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.host_valid = 1'b1; bus.host_we = 1'b1;
            bus.host_addr = 8'h20 + 8'(i); bus.host_wdata = 8'h40 + 8'(i);
            applyStimulus();
        end
        bus.host_valid = 1'b0;
        applyStimulus(3);
        bus.cpu_boundary = 1'b1;
        applyStimulus();
        bus.cpu_boundary = 1'b0;
        applyStimulus(3);
        bus.host_req = 1'b0;
        applyStimulus(3);

        $display("[TB] randomized traffic");
        reqLeft = 0;
        for (int i = 0; i < 1500; i++) begin
            if (reqLeft == 0 && ($urandom % 8) == 0) reqLeft = $urandom_range(1, 30);
            bus.host_req = (reqLeft != 0);
            if (reqLeft != 0) reqLeft--;
            bus.cpu_boundary = (($urandom % 4) == 0);
            bus.cpu_we = (($urandom % 4) == 0);
            bus.cpu_oe = (($urandom % 4) == 0);
            bus.cpu_addr = 8'($urandom) & 8'h3F;
            bus.cpu_wdata = 8'($urandom);
            bus.host_valid = $urandom % 2;
            bus.host_we = $urandom % 2;
            bus.host_addr = 8'($urandom) & 8'h3F;
            bus.host_wdata = 8'($urandom);
            reset = (($urandom % 250) == 0);
            applyStimulus();
        end
        reset = 1'b0;

        $display("[TB] reset during a host write");
        idleInputs();
        bus.cpu_boundary = 1'b1;
        applyStimulus(3);
        bus.host_req = 1'b1;
        applyStimulus(2);
        bus.host_valid = 1'b1; bus.host_we = 1'b1;
        bus.host_addr = 8'h05; bus.host_wdata = 8'hEE;
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        idleInputs();
        applyStimulus(3);

        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("mem[%0h]", i), mem[i], refMem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
